uart_tx_prog: RTL
=================

// Module: uart_tx_prog
//
// PURPOSE
// Serial 8N1 UART transmitter, the transmit side of the boot-programming link
// whose receive side feeds iccm_controller. Reports program-load status and
// readback bytes to the host over the programming UART. Bit period is a runtime
// input, the same 16-bit baud divisor that uart_rx_prog uses. A small byte FIFO
// decouples the producer from the serial line.
//
// PARAMETERS
// FIFO_DEPTH  4  byte FIFO entries; power of 2, >= 2
// STOP_BITS   1  stop bits per frame, 1 or 2
//
// PORTS
// clk_i           in   1   system clock
// rst_ni          in   1   asynchronous reset, active low
// clks_per_bit_i  in   16  clocks per serial bit; 0 is treated as 1
// tx_valid_i      in   1   producer has a byte on tx_byte_i
// tx_byte_i       in   8   byte to send
// tx_ready_o      out  1   FIFO not full; the byte is accepted when valid & ready
// tx_o            out  1   serial line, idle high
// tx_en_o         out  1   pad output enable, high while a frame is on the line
// tx_done_o       out  1   one-cycle pulse when a frame's last stop bit ends
// busy_o          out  1   FSM not IDLE, or FIFO not empty
//
// BEHAVIOUR
// - Reset values: tx_o=1, tx_en_o=0, tx_done_o=0, busy_o=0, tx_ready_o=1.
//   The FIFO is emptied and the FSM goes to IDLE.
// - Handshake: a byte is accepted on an edge where tx_valid_i & tx_ready_o.
//   tx_ready_o = !full, combinational from the FIFO count.
//   A push and a pop on the same edge keep the count unchanged.
//   tx_byte_i may change freely when not accepted.
// - FSM states: IDLE, START, DATA, STOP.
//   - IDLE -> START when the FIFO is non-empty. On that edge: pop the byte,
//     latch cpb = max(clks_per_bit_i,1), clear baud_cnt and bit_idx.
//   - START: drive tx_o=0 for cpb clocks, then go to DATA.
//   - DATA: drive tx_o=shift[bit_idx], LSB first, cpb clocks per bit, for
//     bit_idx 0..7. After bit 7, go to STOP.
//   - STOP: drive tx_o=1 for STOP_BITS*cpb clocks. At the end, pulse tx_done_o.
//     If the FIFO is non-empty, go straight to START (pop and re-latch cpb on
//     the same edge, no idle gap). Otherwise go to IDLE.
// - Latency: the start bit appears on tx_o one clock after the acceptance edge
//   when the block is idle. Frame length is (9+STOP_BITS)*cpb clocks.
// - Baud counter: 16-bit, counts 0..cpb-1. It wraps to 0 at the end of each
//   bit. No overflow is possible.
// - tx_o and tx_en_o are registered, so no glitches. tx_en_o=1 in START, DATA
//   and STOP; 0 in IDLE.
// - Changing clks_per_bit_i mid-frame has no effect until the next frame's latch.
// - When the FIFO is full, tx_ready_o=0 and tx_valid_i is ignored; no byte is
//   lost or overwritten.
// - When the FIFO is empty, IDLE holds tx_o=1 and tx_en_o=0 indefinitely.
// - Reset mid-frame: tx_o goes high asynchronously, the partial frame is
//   abandoned, the FIFO is flushed, and no tx_done_o pulse is produced.
//
// STRUCTURE
// - Package prog_uart_pkg:
//   - tx_state_e enum {IDLE, START, DATA, STOP}
//   - constants UART_DATA_BITS=8 and UART_IDLE_LEVEL=1'b1
//   - the baud divisor width (16), shared with uart_rx_prog
// - Sub-module prog_uart_fifo: sync FIFO, parameterised WIDTH and DEPTH.
//   - ports: push/pop/full/empty/count
//   - read data is from the registered head; no fall-through
// - Top level: the FSM, baud counter, bit index and shift register.
//
// TESTING
// 1. cpb=4, push 0x55, then idle.
//    -> tx_o = 0,1,0,1,0,1,0,1,0,1, each bit held 4 clocks. tx_done_o pulses
//       after 40 clocks. tx_en_o is high for exactly 40 clocks.
// 2. cpb=2, push 0xA3 and 0x0F back to back.
//    -> two frames with no idle gap; tx_done_o pulses twice, 20 clocks apart.
// 3. cpb=8, push 5 bytes with valid held high (FIFO_DEPTH=4).
//    -> tx_ready_o drops only while the FIFO is full. All 5 bytes are sent in
//       order and busy_o falls after the 5th tx_done_o.
// 4. cpb=0, push 0xFF.
//    -> behaves as cpb=1: frame is 10 clocks, tx_o low for exactly 1 clock.
// 5. Change clks_per_bit_i from 4 to 16 during the DATA state of frame 1, with
//    frame 2 queued.
//    -> frame 1 stays at 4 clocks/bit; frame 2 uses 16 clocks/bit.
// 6. Assert rst_ni low during bit 3 of a frame, with 2 bytes queued.
//    -> tx_o=1, tx_en_o=0 and tx_ready_o=1 immediately. After release there is
//       no further activity and no tx_done_o.

Source files
------------

// File: rtl/prog_uart_pkg.sv
// Shared types and constants for the boot-programming UART (tx and rx sides).
package prog_uart_pkg;

  localparam int UART_DIV_W = 16;
  localparam int UART_DATA_BITS = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  // A divisor of 0 would never terminate a bit, so it runs as 1.
  function automatic logic [UART_DIV_W-1:0] cpb_clamp(input logic [UART_DIV_W-1:0] cpb);
    return (cpb == '0) ? UART_DIV_W'(1) : cpb;
  endfunction

endpackage

// File: rtl/prog_uart_fifo.sv
// Small synchronous FIFO; read data comes from the registered head entry.
module prog_uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (PW + 1)'(1);
        2'b01:   cnt <= cnt - (PW + 1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is pure data; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_prog.sv
// 8N1 UART transmitter for the programming link, with a byte FIFO in front
// and a runtime baud divisor latched at the start of every frame.
module uart_tx_prog #(
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [prog_uart_pkg::UART_DIV_W-1:0] clks_per_bit_i,
  input  logic                                tx_valid_i,
  input  logic [7:0]                          tx_byte_i,
  output logic                                tx_ready_o,
  output logic                                tx_o,
  output logic                                tx_en_o,
  output logic                                tx_done_o,
  output logic                                busy_o
);

  import prog_uart_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [7:0]            fifo_rdata;
  logic [CNT_W-1:0]      fifo_count;

  tx_state_e             state_q, state_d;
  logic [UART_DIV_W-1:0] baud_q;
  logic [UART_DIV_W-1:0] cpb_q;
  logic [2:0]            bit_idx_q;
  logic [7:0]            shift_q;
  logic                  tx_q, tx_d;
  logic                  tx_en_q, tx_en_d;
  logic                  done_q, done_d;
  logic                  bit_end;
  logic                  last_data;
  logic                  last_stop;

  assign tx_ready_o = ~fifo_full;
  assign fifo_push  = tx_valid_i & tx_ready_o;

  prog_uart_fifo #(
    .WIDTH(UART_DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (fifo_push),
    .wdata (tx_byte_i),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bit_end   = (baud_q == cpb_q - UART_DIV_W'(1));
  assign last_data = (bit_idx_q == 3'(UART_DATA_BITS - 1));
  assign last_stop = (bit_idx_q == 3'(STOP_BITS - 1));

  assign tx_o      = tx_q;
  assign tx_en_o   = tx_en_q;
  assign tx_done_o = done_q;
  assign busy_o    = (state_q != IDLE) || (fifo_count != '0);

  // Next-state logic also computes the next line level so tx_o is registered.
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    tx_d     = UART_IDLE_LEVEL;
    tx_en_d  = 1'b1;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        tx_en_d = 1'b0;
        if (!fifo_empty) begin
          state_d  = START;
          fifo_pop = 1'b1;
          tx_d     = 1'b0;
          tx_en_d  = 1'b1;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        tx_d = shift_q[bit_idx_q];
        if (bit_end) begin
          if (last_data) begin
            state_d = STOP;
            tx_d    = UART_IDLE_LEVEL;
          end else begin
            tx_d = shift_q[bit_idx_q + 3'd1];
          end
        end
      end
      STOP: begin
        if (bit_end && last_stop) begin
          done_d = 1'b1;
          if (!fifo_empty) begin
            state_d  = START;
            fifo_pop = 1'b1;
            tx_d     = 1'b0;
          end else begin
            state_d = IDLE;
            tx_en_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      tx_q      <= UART_IDLE_LEVEL;
      tx_en_q   <= 1'b0;
      done_q    <= 1'b0;
      baud_q    <= '0;
      bit_idx_q <= '0;
      cpb_q     <= UART_DIV_W'(1);
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      tx_en_q <= tx_en_d;
      done_q  <= done_d;
      if (fifo_pop) begin
        baud_q    <= '0;
        bit_idx_q <= '0;
        cpb_q     <= cpb_clamp(clks_per_bit_i);
      end else if (state_q != IDLE) begin
        if (bit_end) begin
          baud_q <= '0;
          // bit_idx counts data bits, then wraps to 0 and counts stop bits.
          if (state_q == STOP && last_stop) bit_idx_q <= '0;
          else if (state_q != START)        bit_idx_q <= bit_idx_q + 3'd1;
        end else begin
          baud_q <= baud_q + UART_DIV_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (fifo_pop) shift_q <= fifo_rdata;
  end

endmodule
